// File: rtl/xor_parity_pipe_if.sv
// Valid/ready bundle for the XOR parity pipe.
// master drives beats in and accepts results; slave is the engine.
interface xor_parity_pipe_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_word;
  logic              out_par;
  logic [CNT_W-1:0]  out_cnt;

  modport master (
    output mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_par, out_cnt
  );

  modport slave (
    input  mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_word, out_par, out_cnt
  );
endinterface

// File: rtl/xor_parity_pipe.sv
// Two-stage XOR-reduction engine: per-word parity or
// per-frame XOR checksum with beat count.
module xor_parity_pipe #(
  parameter int DATA_W  = 8,
  parameter int GROUP_W = 4,
  parameter int ODD_PAR = 0,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  xor_parity_pipe_if.slave bus
);

  localparam int   NL  = (DATA_W + GROUP_W - 1) / GROUP_W;
  localparam int   PW  = NL * GROUP_W;
  localparam logic ODD = (ODD_PAR != 0);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e            state_q, state_d;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_last_q;
  logic              s1_mode_q;
  logic [NL-1:0]     s1_lane_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] ow_q, ow_d;
  logic              op_q, op_d;
  logic [CNT_W-1:0]  oc_q, oc_d;

  logic              s2_adv;
  logic              s1_adv;
  logic              load;
  logic [PW-1:0]     pad;
  logic [NL-1:0]     lane_d;
  logic              frame;
  logic [DATA_W-1:0] word_x;
  logic              par_x;
  logic [CNT_W-1:0]  cnt_x;

  assign s2_adv = !ov_q || bus.out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign load   = s1_valid_q && s2_adv;

  assign bus.in_ready  = s1_adv && !rst;
  assign bus.out_valid = ov_q;
  assign bus.out_word  = ow_q;
  assign bus.out_par   = op_q;
  assign bus.out_cnt   = oc_q;

  // Lane parities of the incoming word; pad bits past DATA_W read as 0.
  always_comb begin
    pad = '0;
    pad[DATA_W-1:0] = bus.in_data;
    lane_d = '0;
    for (int l = 0; l < NL; l++) begin
      lane_d[l] = ^pad[l*GROUP_W +: GROUP_W];
    end
  end

  // Stage 1: capture a beat whenever the slot is free or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_lane_q  <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data_q <= bus.in_data;
        s1_last_q <= bus.in_last;
        s1_mode_q <= bus.mode;
        s1_lane_q <= lane_d;
      end
    end
  end

  // Stage 2 next state: accumulate mid-frame beats, emit everything else.
  // acc and cnt are zero in IDLE, so one datapath covers both modes.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    ow_d    = ow_q;
    op_d    = op_q;
    oc_d    = oc_q;
    frame   = (state_q == ACCUM) || s1_mode_q;
    word_x  = acc_q ^ s1_data_q;
    par_x   = (^s1_lane_q) ^ (^acc_q) ^ ODD;
    cnt_x   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    if (s2_adv) begin
      ov_d = 1'b0;
    end
    if (load) begin
      if (frame && !s1_last_q) begin
        state_d = ACCUM;
        acc_d   = word_x;
        cnt_d   = cnt_x;
      end else begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ov_d    = 1'b1;
        ow_d    = word_x;
        op_d    = par_x;
        oc_d    = cnt_x;
      end
    end
  end

  // Frame-tracking state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, beat counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      ow_q  <= '0;
      op_q  <= 1'b0;
      oc_q  <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
      ow_q  <= ow_d;
      op_q  <= op_d;
      oc_q  <= oc_d;
    end
  end

endmodule

// File: tb/tb_xor_parity_pipe.sv
// Scoreboard bench for xor_parity_pipe: even parity with 4-bit lanes
// and odd parity with partial 3-bit lanes, driven by the same beats.
module tb_xor_parity_pipe;
  localparam int DW = 8;
  localparam int CW = 8;

  typedef struct {
    logic [DW-1:0] w;
    logic          p;
    logic [CW-1:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xor_parity_pipe_if #(.DATA_W(DW), .CNT_W(CW)) b0();
  xor_parity_pipe_if #(.DATA_W(DW), .CNT_W(CW)) b1();

  xor_parity_pipe #(
    .DATA_W(DW), .GROUP_W(4), .ODD_PAR(0), .CNT_W(CW)
  ) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  xor_parity_pipe #(
    .DATA_W(DW), .GROUP_W(3), .ODD_PAR(1), .CNT_W(CW)
  ) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  assign b1.mode      = b0.mode;
  assign b1.in_valid  = b0.in_valid;
  assign b1.in_data   = b0.in_data;
  assign b1.in_last   = b0.in_last;
  assign b1.out_ready = b0.out_ready;

  exp_t q0[$];
  exp_t q1[$];
  int n_vec = 0;
  int n_mis = 0;
  int acc_cnt = 0;
  bit hold = 0;
  bit bp = 0;
  bit in_frame = 0;
  logic [DW-1:0] fw[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(logic [DW-1:0] w, int n);
    exp_t e;
    e.w = w;
    e.c = (n > 255) ? 8'd255 : n[CW-1:0];
    e.p = ($countones(w) % 2) == 1;
    q0.push_back(e);
    e.p = ($countones(w) % 2) == 0;
    q1.push_back(e);
  endtask

  // Reference: a frame is a list of words; its result is their XOR.
  task automatic model_beat(logic m, logic [DW-1:0] d, logic l);
    logic [DW-1:0] x;
    if (!in_frame && !m) begin
      push_exp(d, 1);
    end else begin
      fw.push_back(d);
      if (l) begin
        x = '0;
        foreach (fw[i]) x = x ^ fw[i];
        push_exp(x, fw.size());
        fw.delete();
        in_frame = 0;
      end else begin
        in_frame = 1;
      end
    end
  endtask

  task automatic send(logic m, logic [DW-1:0] d, logic l);
    int t;
    t = 0;
    @(negedge clk);
    b0.mode = m;
    b0.in_data = d;
    b0.in_last = l;
    b0.in_valid = 1'b1;
    #1;
    while (!b0.in_ready && t < 1000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 1000) begin
      n_vec++;
      n_mis++;
      $display("FAIL in_ready timeout: got 0 want 1");
    end else begin
      model_beat(m, d, l);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain timeout: got %0d pending want 0", q0.size());
    end
  endtask

  always @(negedge clk) begin
    b0.out_ready = hold ? 1'b0 : (bp ? ($urandom_range(3) != 0) : 1'b1);
  end

  bit st0 = 0;
  bit st1 = 0;
  logic [17:0] h0, h1;
  exp_t e0, e1;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      st0 = 0;
      st1 = 0;
    end else begin
      if (st0) chk("stall hold0", {b0.out_valid, b0.out_word, b0.out_par, b0.out_cnt}, h0);
      if (st1) chk("stall hold1", {b1.out_valid, b1.out_word, b1.out_par, b1.out_cnt}, h1);
      st0 = b0.out_valid && !b0.out_ready;
      st1 = b1.out_valid && !b1.out_ready;
      h0 = {b0.out_valid, b0.out_word, b0.out_par, b0.out_cnt};
      h1 = {b1.out_valid, b1.out_word, b1.out_par, b1.out_cnt};
      if (b0.out_valid && b0.out_ready) begin
        if (q0.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL out0 extra: got %0h want none", b0.out_word);
        end else begin
          e0 = q0.pop_front();
          chk("word0", b0.out_word, e0.w);
          chk("par0", b0.out_par, e0.p);
          chk("cnt0", b0.out_cnt, e0.c);
        end
      end
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL out1 extra: got %0h want none", b1.out_word);
        end else begin
          e1 = q1.pop_front();
          chk("word1", b1.out_word, e1.w);
          chk("par1", b1.out_par, e1.p);
          chk("cnt1", b1.out_cnt, e1.c);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    b0.mode = 1'b0;
    b0.in_valid = 1'b0;
    b0.in_data = '0;
    b0.in_last = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst out_valid", b0.out_valid, 0);
    chk("rst in_ready", b0.in_ready, 0);
    chk("rst out_word", b0.out_word, 0);
    chk("rst out_cnt", b0.out_cnt, 0);
    chk("rst out_par1", b1.out_par, 0);
    @(negedge clk);
    rst = 1'b0;

    send(0, 8'hA5, 0);
    send(0, 8'h01, 0);
    send(0, 8'hFF, 0);
    drain();

    send(0, 8'h00, 0);
    send(0, 8'h80, 0);
    drain();

    send(1, 8'h0F, 0);
    send(1, 8'hF0, 0);
    send(1, 8'h3C, 1);
    drain();

    hold = 1;
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(0, 8'(8'h30 + i), 0);
      end
      begin
        repeat (5) @(negedge clk);
        #1;
        chk("stall accepted", acc_cnt, 2);
        chk("stall in_ready", b0.in_ready, 0);
        hold = 0;
      end
    join
    drain();

    send(1, 8'($urandom), 0);
    send(0, 8'($urandom), 0);
    send(0, 8'($urandom), 0);
    send(0, 8'($urandom), 1);
    drain();

    send(1, 8'h5A, 0);
    send(1, 8'hC3, 0);
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", b0.out_valid, 0);
    chk("midrst in_ready", b0.in_ready, 0);
    chk("midrst in_ready1", b1.in_ready, 0);
    in_frame = 0;
    fw.delete();
    @(negedge clk);
    rst = 1'b0;
    send(1, 8'h11, 1);
    drain();

    bp = 1;
    for (int i = 0; i < 299; i++) send(1, 8'($urandom), 0);
    send(1, 8'($urandom), 1);
    drain();

    for (int i = 0; i < 300; i++) begin
      send(1'($urandom), 8'($urandom), $urandom_range(3) == 0);
    end
    send(1, 8'($urandom), 1);
    drain();
    bp = 0;

    chk("leftover0", q0.size(), 0);
    chk("leftover1", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
